lbp_window_sched: RTL

LBP_WINDOW_SCHED -- requirements
Module: lbp_window_sched

---
 rtl/lbp_pkg.sv | 24 ++
 rtl/lbp_addr_gen.sv | 70 +++++++
 rtl/lbp_window_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, FSM encoding and window-slot helper for the LBP 3x3
// window scheduler.
package lbp_pkg;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;
  localparam int WIN_N  = 9;
  localparam int CENTER = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Window slot holding pixel (row, col): rows are stored three slots apart.
  function automatic logic [3:0] win_slot(input logic [1:0] col, input logic [1:0] row);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction
endpackage

// File: rtl/lbp_addr_gen.sv
// Window-center x/y counters and gray-memory read address generation; the
// address is computed from the position the scheduler will occupy next cycle.
module lbp_addr_gen #(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int IMG_H  = lbp_pkg::IMG_H,
  parameter int ADDR_W = lbp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              step,
  input  logic [1:0]        col_off,
  input  logic [1:0]        row_off,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] center_addr,
  output logic              last_col,
  output logic              last_row
);
  import lbp_pkg::*;

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] x_r;
  logic [ADDR_W-1:0] y_r;
  logic [ADDR_W-1:0] x_nxt_s;
  logic [ADDR_W-1:0] y_nxt_s;

  assign last_col = (x_r == X_LAST);
  assign last_row = (y_r == Y_LAST);

  // Next center position: restart at (1,1), advance in raster order, or hold.
  always_comb begin
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    if (init) begin
      x_nxt_s = ONE;
      y_nxt_s = ONE;
    end else if (step) begin
      if (last_col) begin
        x_nxt_s = ONE;
        y_nxt_s = y_r + ONE;
      end else begin
        x_nxt_s = x_r + ONE;
        y_nxt_s = y_r;
      end
    end else begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
    end
  end

  // Offsets are relative to the window's top-left pixel (x-1, y-1).
  assign rd_addr = W_A * (y_nxt_s - ONE + {{(ADDR_W-2){1'b0}}, row_off})
                 + (x_nxt_s - ONE + {{(ADDR_W-2){1'b0}}, col_off});
  assign center_addr = W_A * y_r + x_r;

  // Center counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r <= ONE;
      y_r <= ONE;
    end else begin
      x_r <= x_nxt_s;
      y_r <= y_nxt_s;
    end
  end
endmodule

// File: rtl/lbp_window_sched.sv
// Raster-order 3x3 window scheduler: fetches pixels from gray memory, keeps a
// sliding window and presents each full window to the LBP datapath.
module lbp_window_sched #(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int IMG_H  = lbp_pkg::IMG_H,
  parameter int ADDR_W = lbp_pkg::ADDR_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  output logic                                      gray_req,
  output logic [ADDR_W-1:0]                         gray_addr,
  input  logic                                      gray_ready,
  input  logic [lbp_pkg::PIX_W-1:0]                 gray_data,
  output logic                                      win_valid,
  input  logic                                      win_ready,
  output logic [lbp_pkg::WIN_N*lbp_pkg::PIX_W-1:0]  win_data,
  output logic [ADDR_W-1:0]                         win_addr,
  output logic                                      finish,
  output logic                                      busy
);
  import lbp_pkg::*;

  state_t            state_r;
  logic [1:0]        col_r;
  logic [1:0]        row_r;
  logic              pend_r;
  logic [3:0]        pend_slot_r;
  logic [PIX_W-1:0]  win_r [WIN_N];
  logic              gray_req_r;
  logic [ADDR_W-1:0] gray_addr_r;
  logic              win_valid_r;
  logic [ADDR_W-1:0] win_addr_r;
  logic              finish_r;
  logic              busy_r;

  logic              init_s;
  logic              step_s;
  logic [1:0]        nxt_col_s;
  logic [1:0]        nxt_row_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] center_addr_s;
  logic              last_col_s;
  logic              last_row_s;

  lbp_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .init        (init_s),
    .step        (step_s),
    .col_off     (nxt_col_s),
    .row_off     (nxt_row_s),
    .rd_addr     (rd_addr_s),
    .center_addr (center_addr_s),
    .last_col    (last_col_s),
    .last_row    (last_row_s)
  );

  // Select the window cell of the request to present next cycle.
  always_comb begin
    init_s    = 1'b0;
    step_s    = 1'b0;
    nxt_col_s = 2'd0;
    nxt_row_s = 2'd0;
    case (state_r)
      S_IDLE: init_s = start;
      S_FILL: begin
        if (row_r != 2'd2) begin
          nxt_col_s = col_r;
          nxt_row_s = row_r + 2'd1;
        end else if (col_r != 2'd2) begin
          nxt_col_s = col_r + 2'd1;
          nxt_row_s = 2'd0;
        end else begin
          nxt_col_s = 2'd2;
          nxt_row_s = 2'd2;
        end
      end
      S_SHIFT: begin
        nxt_col_s = 2'd2;
        nxt_row_s = (row_r == 2'd2) ? 2'd2 : row_r + 2'd1;
      end
      S_EMIT: begin
        step_s    = win_ready & ~(last_col_s & last_row_s);
        nxt_col_s = last_col_s ? 2'd0 : 2'd2;
        nxt_row_s = 2'd0;
      end
      default: begin
        init_s    = 1'b0;
        step_s    = 1'b0;
        nxt_col_s = 2'd0;
        nxt_row_s = 2'd0;
      end
    endcase
  end

  // Scheduler FSM, window registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      col_r       <= 2'd0;
      row_r       <= 2'd0;
      pend_r      <= 1'b0;
      pend_slot_r <= 4'd0;
      gray_req_r  <= 1'b0;
      gray_addr_r <= {ADDR_W{1'b0}};
      win_valid_r <= 1'b0;
      win_addr_r  <= {ADDR_W{1'b0}};
      finish_r    <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_r[i] <= {PIX_W{1'b0}};
    end else begin
      finish_r <= 1'b0;
      pend_r   <= gray_req_r & gray_ready;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r     <= S_FILL;
            busy_r      <= 1'b1;
            gray_req_r  <= 1'b1;
            gray_addr_r <= rd_addr_s;
            col_r       <= 2'd0;
            row_r       <= 2'd0;
          end
        end
        S_FILL, S_SHIFT: begin
          if (gray_ready) begin
            pend_slot_r <= win_slot(col_r, row_r);
            if (col_r == 2'd2 && row_r == 2'd2) begin
              gray_req_r <= 1'b0;
              state_r    <= S_WAIT;
            end else begin
              gray_addr_r <= rd_addr_s;
              col_r       <= nxt_col_s;
              row_r       <= nxt_row_s;
            end
          end
        end
        S_WAIT: begin
          state_r     <= S_EMIT;
          win_valid_r <= 1'b1;
          win_addr_r  <= center_addr_s;
        end
        S_EMIT: begin
          if (win_ready) begin
            win_valid_r <= 1'b0;
            if (!last_col_s) begin
              // Slide left by one column; column 2 is refetched in SHIFT.
              for (int r = 0; r < 3; r++) begin
                win_r[3*r]   <= win_r[3*r+1];
                win_r[3*r+1] <= win_r[3*r+2];
              end
              state_r     <= S_SHIFT;
              gray_req_r  <= 1'b1;
              gray_addr_r <= rd_addr_s;
              col_r       <= 2'd2;
              row_r       <= 2'd0;
            end else if (!last_row_s) begin
              state_r     <= S_FILL;
              gray_req_r  <= 1'b1;
              gray_addr_r <= rd_addr_s;
              col_r       <= 2'd0;
              row_r       <= 2'd0;
            end else begin
              state_r  <= S_DONE;
              finish_r <= 1'b1;
              busy_r   <= 1'b0;
            end
          end
        end
        S_DONE: state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
      if (pend_r) win_r[pend_slot_r] <= gray_data;
    end
  end

  // Pack the window registers onto the output bus.
  always_comb begin
    win_data = {(WIN_N*PIX_W){1'b0}};
    for (int i = 0; i < WIN_N; i++) win_data[PIX_W*i +: PIX_W] = win_r[i];
  end

  assign gray_req  = gray_req_r;
  assign gray_addr = gray_addr_r;
  assign win_valid = win_valid_r;
  assign win_addr  = win_addr_r;
  assign finish    = finish_r;
  assign busy      = busy_r;
endmodule
